// File: rtl/grant_ack_source.sv
// grant_ack_source: turns completed Grant/GrantData responses into E-channel GrantAcks
// and mirrors every response beat to the MSHRs. Optional counter: GRANT_ACK_STATS_EN.
module grant_ack_source #(
  parameter int SOURCE_W  = 3,
  parameter int SINK_W    = 3,
  parameter int ACK_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                resp_valid,
  input  logic                resp_last,
  input  logic [2:0]          resp_opcode,
  input  logic [2:0]          resp_param,
  input  logic [SOURCE_W-1:0] resp_source,
  input  logic [SINK_W-1:0]   resp_sink,
  input  logic                resp_denied,
  output logic                grant_safe,
  output logic                e_valid,
  input  logic                e_ready,
  output logic [SINK_W-1:0]   e_sink,
  output logic                mshr_valid,
  output logic                mshr_last,
  output logic [2:0]          mshr_opcode,
  output logic [2:0]          mshr_param,
  output logic [SOURCE_W-1:0] mshr_source,
  output logic                mshr_denied,
  output logic                overflow_err,
  output logic [15:0]         ack_count
);

  localparam int PTR_W = $clog2(ACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ACK_DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(ACK_DEPTH);

  logic [SINK_W-1:0] ack_mem [ACK_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              inflight;

  logic is_grant;
  logic enq;
  logic deq;
  logic full;
  logic push;
  logic overflow;
  logic first_beat;

  assign is_grant   = (resp_opcode == 3'd4) || (resp_opcode == 3'd5);
  assign enq        = resp_valid && resp_last && is_grant;
  assign first_beat = resp_valid && !resp_last && is_grant;
  assign full       = (count == DEPTH_CNT);
  assign deq        = e_valid && e_ready;
  // A full FIFO can still take an entry when the head leaves in the same cycle.
  assign push       = enq && (!full || deq);
  assign overflow   = enq && full && !deq;

  assign e_valid    = (count != '0);
  assign e_sink     = ack_mem[rd_ptr];
  // An open multi-beat GrantData already owns a slot it will need on its last beat.
  assign grant_safe = ({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_SUM;

  always_ff @(posedge clock) begin
    if (push) begin
      ack_mem[wr_ptr] <= resp_sink;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (enq) begin
        inflight <= 1'b0;
      end else if (first_beat) begin
        inflight <= 1'b1;
      end
      if (overflow) begin
        overflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mshr_valid  <= 1'b0;
      mshr_last   <= 1'b0;
      mshr_opcode <= 3'd0;
      mshr_param  <= 3'd0;
      mshr_source <= '0;
      mshr_denied <= 1'b0;
    end else begin
      mshr_valid <= resp_valid;
      if (resp_valid) begin
        mshr_last   <= resp_last;
        mshr_opcode <= resp_opcode;
        mshr_param  <= resp_param;
        mshr_source <= resp_source;
        mshr_denied <= resp_denied;
      end
    end
  end

`ifdef GRANT_ACK_STATS_EN
  logic [15:0] ack_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_count_q <= 16'h0;
    end else if (deq && (ack_count_q != 16'hFFFF)) begin
      ack_count_q <= ack_count_q + 16'h1;
    end
  end

  assign ack_count = ack_count_q;
`else
  assign ack_count = 16'h0;
`endif

`ifndef SYNTHESIS
  // The sink is expected to honour grant_safe, so a dropped ack indicates a protocol bug upstream.
  always @(posedge clock) begin
    if (!reset) begin
      overflow_check: assert (!overflow)
        else $warning("grant_ack_source: GrantAck dropped, ack queue full");
    end
  end
`endif

endmodule

// File: tb/tb_grant_ack_source.sv
// Table-driven bench for grant_ack_source: one vector per clock cycle, plus a short
// hand sequence for MSHR payload fields, ack stability under back-pressure and ack_count.
module tb_grant_ack_source;

  logic       clock;
  logic       reset;
  logic       resp_valid;
  logic       resp_last;
  logic [2:0] resp_opcode;
  logic [2:0] resp_param;
  logic [2:0] resp_source;
  logic [2:0] resp_sink;
  logic       resp_denied;
  logic       grant_safe;
  logic       e_valid;
  logic       e_ready;
  logic [2:0] e_sink;
  logic       mshr_valid;
  logic       mshr_last;
  logic [2:0] mshr_opcode;
  logic [2:0] mshr_param;
  logic [2:0] mshr_source;
  logic       mshr_denied;
  logic       overflow_err;
  logic [15:0] ack_count;

  int checks;
  int errors;

  grant_ack_source #(.SOURCE_W(3), .SINK_W(3), .ACK_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .resp_valid  (resp_valid),
    .resp_last   (resp_last),
    .resp_opcode (resp_opcode),
    .resp_param  (resp_param),
    .resp_source (resp_source),
    .resp_sink   (resp_sink),
    .resp_denied (resp_denied),
    .grant_safe  (grant_safe),
    .e_valid     (e_valid),
    .e_ready     (e_ready),
    .e_sink      (e_sink),
    .mshr_valid  (mshr_valid),
    .mshr_last   (mshr_last),
    .mshr_opcode (mshr_opcode),
    .mshr_param  (mshr_param),
    .mshr_source (mshr_source),
    .mshr_denied (mshr_denied),
    .overflow_err(overflow_err),
    .ack_count   (ack_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rst;
    logic       v;
    logic       last;
    logic [2:0] op;
    logic [2:0] src;
    logic [2:0] snk;
    logic       rdy;
    logic       ev;
    logic [2:0] es;
    logic       gs;
    logic       mv;
    logic [2:0] mop;
    logic [2:0] msrc;
    logic       ovf;
  } vec_t;

  vec_t table_q[$];

  function automatic vec_t mk(logic rst, logic v, logic last, logic [2:0] op, logic [2:0] src,
                              logic [2:0] snk, logic rdy, logic ev, logic [2:0] es, logic gs,
                              logic mv, logic [2:0] mop, logic [2:0] msrc, logic ovf);
    vec_t r;
    r.rst = rst; r.v = v; r.last = last; r.op = op; r.src = src; r.snk = snk; r.rdy = rdy;
    r.ev = ev; r.es = es; r.gs = gs; r.mv = mv; r.mop = mop; r.msrc = msrc; r.ovf = ovf;
    return r;
  endfunction

  // Drives one cycle of inputs, then samples 1 time unit after the clock edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic last,
                               input logic [2:0] op, input logic [2:0] param, input logic den,
                               input logic [2:0] src, input logic [2:0] snk, input logic rdy);
    reset       = rst;
    resp_valid  = v;
    resp_last   = last;
    resp_opcode = op;
    resp_param  = param;
    resp_denied = den;
    resp_source = src;
    resp_sink   = snk;
    e_ready     = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int row, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, row, actual, expected);
    end
  endtask

  initial begin
    logic [15:0] exp_acks;
    checks = 0;
    errors = 0;
    reset = 1'b1; resp_valid = 1'b0; resp_last = 1'b0; resp_opcode = 3'd0; resp_param = 3'd0;
    resp_source = 3'd0; resp_sink = 3'd0; resp_denied = 1'b0; e_ready = 1'b0;

    //                rst v l op src snk rdy | ev es gs mv mop msrc ovf
    table_q.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0));
    // single-beat Grant, accepted immediately
    table_q.push_back(mk(0, 1, 1, 4, 2, 5, 1,  1, 5, 1, 1, 4, 2, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 4, 2, 0));
    // ReleaseAck: forwarded to MSHR, no E traffic
    table_q.push_back(mk(0, 1, 1, 6, 3, 7, 1,  0, 0, 1, 1, 6, 3, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 6, 3, 0));
    // fill with sinks 1..4 under back-pressure
    table_q.push_back(mk(0, 1, 1, 4, 1, 1, 0,  1, 1, 1, 1, 4, 1, 0));
    table_q.push_back(mk(0, 1, 1, 4, 2, 2, 0,  1, 1, 1, 1, 4, 2, 0));
    table_q.push_back(mk(0, 1, 1, 4, 3, 3, 0,  1, 1, 1, 1, 4, 3, 0));
    table_q.push_back(mk(0, 1, 1, 4, 4, 4, 0,  1, 1, 0, 1, 4, 4, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 4, 4, 0));
    // full: enq+deq together is legal, then enq without deq overflows
    table_q.push_back(mk(0, 1, 1, 5, 6, 7, 1,  1, 2, 0, 1, 5, 6, 0));
    table_q.push_back(mk(0, 1, 1, 4, 5, 6, 0,  1, 2, 0, 1, 4, 5, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 3, 1, 0, 4, 5, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 4, 1, 0, 4, 5, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 7, 1, 0, 4, 5, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 4, 5, 1));
    // three queued acks, then an 8-beat GrantData
    table_q.push_back(mk(0, 1, 1, 4, 0, 1, 0,  1, 1, 1, 1, 4, 0, 1));
    table_q.push_back(mk(0, 1, 1, 4, 0, 2, 0,  1, 1, 1, 1, 4, 0, 1));
    table_q.push_back(mk(0, 1, 1, 4, 0, 3, 0,  1, 1, 1, 1, 4, 0, 1));
    for (int b = 1; b <= 7; b++) begin
      table_q.push_back(mk(0, 1, 0, 5, 4, 5, 0,  1, 1, 0, 1, 5, 4, 1));
    end
    table_q.push_back(mk(0, 1, 1, 5, 4, 5, 0,  1, 1, 0, 1, 5, 4, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 2, 1, 0, 5, 4, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 3, 1, 0, 5, 4, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 5, 1, 0, 5, 4, 1));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 5, 4, 1));
    // reset with two acks queued
    table_q.push_back(mk(0, 1, 1, 4, 1, 6, 0,  1, 6, 1, 1, 4, 1, 1));
    table_q.push_back(mk(0, 1, 1, 4, 2, 2, 0,  1, 6, 1, 1, 4, 2, 1));
    table_q.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0));

    foreach (table_q[i]) begin
      applyStimulus(table_q[i].rst, table_q[i].v, table_q[i].last, table_q[i].op, 3'd0, 1'b0,
                    table_q[i].src, table_q[i].snk, table_q[i].rdy);
      checkOutput("e_valid", i, 16'(e_valid), 16'(table_q[i].ev));
      if (table_q[i].ev) begin
        checkOutput("e_sink", i, 16'(e_sink), 16'(table_q[i].es));
      end
      checkOutput("grant_safe", i, 16'(grant_safe), 16'(table_q[i].gs));
      checkOutput("mshr_valid", i, 16'(mshr_valid), 16'(table_q[i].mv));
      checkOutput("mshr_opcode", i, 16'(mshr_opcode), 16'(table_q[i].mop));
      checkOutput("mshr_source", i, 16'(mshr_source), 16'(table_q[i].msrc));
      checkOutput("overflow_err", i, 16'(overflow_err), 16'(table_q[i].ovf));
      if (table_q[i].rst) begin
        checkOutput("ack_count_reset", i, ack_count, 16'h0);
      end
    end

    // MSHR payload fields, ack held while e_ready is low, then one accepted ack
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 3'd6, 1'b1, 3'd7, 3'd3, 1'b0);
    checkOutput("mshr_param", 100, 16'(mshr_param), 16'd6);
    checkOutput("mshr_denied", 100, 16'(mshr_denied), 16'd1);
    checkOutput("mshr_last", 100, 16'(mshr_last), 16'd1);
    checkOutput("mshr_source", 100, 16'(mshr_source), 16'd7);
    checkOutput("e_sink", 100, 16'(e_sink), 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    checkOutput("e_valid_held", 101, 16'(e_valid), 16'd1);
    checkOutput("e_sink_held", 101, 16'(e_sink), 16'd3);
    checkOutput("mshr_param_held", 101, 16'(mshr_param), 16'd6);
    checkOutput("mshr_valid", 101, 16'(mshr_valid), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
    checkOutput("e_valid_drained", 102, 16'(e_valid), 16'd0);
`ifdef GRANT_ACK_STATS_EN
    exp_acks = 16'd1;
`else
    exp_acks = 16'd0;
`endif
    checkOutput("ack_count", 102, ack_count, exp_acks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
